// File: rtl/frame_sequencer.sv
// Per-frame controller: free-running frame tick, one move update then one
// raycast request per column per frame, and a saturating dropped-tick count.
module frame_sequencer #(
    parameter int unsigned FRAME_CYCLES = 833334,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned COLS         = 320,
    parameter int unsigned COL_W        = 9
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             enable,
    input  logic             move_done,
    input  logic             cast_done,
    output logic             tick,
    output logic             move_start,
    output logic             cast_start,
    output logic [COL_W-1:0] col,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       overrun_count
);

    typedef enum logic [2:0] {
        StIdle,
        StMoveReq,
        StMoveWait,
        StCastReq,
        StCastWait,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] CntReload = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [COL_W-1:0] ColLast   = COL_W'(COLS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       ovr_q, ovr_d;

    // Tick down-counter, independent of enable and FSM state.
    always_comb begin
        tick  = (cnt_q == '0);
        cnt_d = tick ? CntReload : cnt_q - CNT_W'(1);
    end

    // Next-state, column index and overrun count.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        ovr_d   = ovr_q;

        // A tick arriving mid-frame is dropped, not queued.
        if (tick && enable && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (tick && enable) begin
                    state_d = StMoveReq;
                    col_d   = '0;
                end
            end
            StMoveReq: state_d = StMoveWait;
            StMoveWait: begin
                if (move_done) state_d = StCastReq;
            end
            StCastReq: state_d = StCastWait;
            StCastWait: begin
                if (cast_done) begin
                    if (col_q == ColLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StCastReq;
                        col_d   = col_q + COL_W'(1);
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= CntReload;
            col_q   <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            ovr_q   <= ovr_d;
        end
    end

    // Moore outputs decoded from registered state.
    always_comb begin
        move_start    = (state_q == StMoveReq);
        cast_start    = (state_q == StCastReq);
        frame_done    = (state_q == StDone);
        busy          = (state_q != StIdle);
        col           = col_q;
        overrun_count = ovr_q;
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer with a short frame period.
module tb_frame_sequencer;

    localparam int FC = 64;
    localparam int NC = 4;
    localparam int CW = 2;

    logic          clkin = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          move_done = 1'b0;
    logic          cast_done = 1'b0;
    logic          tick, move_start, cast_start, busy, frame_done;
    logic [CW-1:0] col;
    logic [7:0]    overrun_count;

    frame_sequencer #(
        .FRAME_CYCLES(FC),
        .CNT_W       (6),
        .COLS        (NC),
        .COL_W       (CW)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .enable       (enable),
        .move_done    (move_done),
        .cast_done    (cast_done),
        .tick         (tick),
        .move_start   (move_start),
        .cast_start   (cast_start),
        .col          (col),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun_count(overrun_count)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic       md, cd, tk, ms, cs;
        logic [1:0] cl;
        logic       bz, fd;
    } vec_t;

    vec_t tbl[13];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Responder state and event log.
    bit mpend = 0;
    bit cpend = 0;
    int ms_q[$];
    int fd_n = 0;
    int fd_cyc = -1;
    bit ov_dec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    // Advance until tick is high in the current cycle, within a cycle budget.
    task automatic wait_tick(input int budget, output int at);
        int n;
        n  = 0;
        at = -1;
        while (at < 0 && n < budget) begin
            if (tick === 1'b1) at = cyc;
            else begin
                step();
                n++;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout: got none expected tick within %0d cycles", budget);
        end
    endtask

    // Client model: answers each start one cycle later unless stalled.
    task automatic respond(input int n, input bit stall_move, input int stall_col,
                           input int stall_end);
        logic [7:0] prev_ov;
        prev_ov = overrun_count;
        for (int i = 0; i < n; i++) begin
            if (move_start) ms_q.push_back(cyc);
            if (frame_done) begin
                fd_n++;
                fd_cyc = cyc;
            end
            if (overrun_count < prev_ov) ov_dec = 1;
            prev_ov   = overrun_count;
            move_done = mpend && !(stall_move && cyc < stall_end);
            if (move_done) mpend = 0;
            cast_done = cpend && !((int'(col) == stall_col) && cyc < stall_end);
            if (cast_done) cpend = 0;
            if (move_start) mpend = 1;
            if (cast_start) cpend = 1;
            step();
        end
        move_done = 0;
        cast_done = 0;
    endtask

    initial begin
        int rel, t, t2, t3, t4, at, nticks, nstart, nbusy, nfd, ncol, novr;

        tbl[0]  = '{0, 0, 1, 0, 0, 2'd0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 2'd0, 1, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 2'd0, 1, 0};
        tbl[3]  = '{1, 0, 0, 0, 1, 2'd0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 2'd0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 1, 2'd1, 1, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 2'd1, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 2'd2, 1, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 2'd2, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 2'd3, 1, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 2'd3, 1, 0};
        tbl[11] = '{0, 1, 0, 0, 0, 2'd3, 1, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 2'd3, 0, 0};

        // Reset and idle.
        reset  = 1;
        enable = 1;
        repeat (3) step();
        reset = 0;
        rel   = cyc - 1;
        chk("rst_tick", tick, 0);
        chk("rst_move_start", move_start, 0);
        chk("rst_cast_start", cast_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_col", col, 0);
        chk("rst_overrun", overrun_count, 0);
        wait_tick(100, at);
        chk("first_tick_cycle", at - rel, FC);
        t = at;

        // Nominal frame, with spurious dones outside their wait states.
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("nom%0d_tick", i), tick, tbl[i].tk);
            chk($sformatf("nom%0d_move_start", i), move_start, tbl[i].ms);
            chk($sformatf("nom%0d_cast_start", i), cast_start, tbl[i].cs);
            chk($sformatf("nom%0d_col", i), col, tbl[i].cl);
            chk($sformatf("nom%0d_busy", i), busy, tbl[i].bz);
            chk($sformatf("nom%0d_frame_done", i), frame_done, tbl[i].fd);
            move_done = tbl[i].md;
            cast_done = tbl[i].cd;
            step();
        end
        move_done = 0;
        cast_done = 0;
        wait_tick(100, at);
        chk("second_tick_period", at - t, FC);
        t2 = at;

        // Overrun: stall cast at column 1 for 150 cycles.
        ms_q.delete();
        fd_n = 0;
        respond(200, 0, 1, t2 + 150);
        chk("ovr_count", overrun_count, 2);
        chk("ovr_frame_done_n", fd_n, 1);
        chk("ovr_frame_done_cyc", fd_cyc - t2, 155);
        chk("ovr_starts", ms_q.size(), 2);
        if (ms_q.size() == 2) begin
            chk("ovr_first_start", ms_q[0] - t2, 1);
            chk("ovr_next_start", ms_q[1] - t2, 193);
        end
        respond(20, 0, -1, 0);
        chk("ovr_second_frame_done", fd_n, 2);
        chk("ovr_idle_after", busy, 0);

        // Saturation: stall move_done across 300 ticks.
        wait_tick(100, at);
        t3 = at;
        ms_q.delete();
        fd_n   = 0;
        ov_dec = 0;
        respond(300 * FC + 10, 1, -1, t3 + 300 * FC + 10);
        chk("sat_count", overrun_count, 255);
        chk("sat_no_wrap", ov_dec, 0);
        chk("sat_single_start", ms_q.size(), 1);
        chk("sat_busy_held", busy, 1);
        respond(20, 0, -1, 0);
        chk("sat_frame_done", fd_n, 1);
        chk("sat_idle_after", busy, 0);
        chk("sat_count_held", overrun_count, 255);

        // Reset mid-frame in CAST_WAIT at column 2.
        wait_tick(100, at);
        t4 = at;
        fd_n = 0;
        respond(12, 0, 2, t4 + 1000);
        chk("mid_busy", busy, 1);
        chk("mid_col", col, 2);
        chk("mid_cast_start", cast_start, 0);
        reset = 1;
        step();
        reset  = 0;
        enable = 0;
        mpend  = 0;
        cpend  = 0;
        rel    = cyc - 1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_col", col, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_overrun", overrun_count, 0);
        cast_done = 1;
        step();
        cast_done = 0;
        chk("late_done_busy", busy, 0);
        chk("late_done_cast_start", cast_start, 0);
        chk("late_done_frame_done", frame_done, 0);
        chk("late_done_col", col, 0);
        chk("mid_frame_done_n", fd_n, 0);
        wait_tick(100, at);
        chk("mid_tick_cycle", at - rel, FC);

        // Enable low with random spurious dones over several ticks.
        nticks = 0; nstart = 0; nbusy = 0; nfd = 0; ncol = 0; novr = 0;
        for (int i = 0; i < 3 * FC + 10; i++) begin
            if (tick) nticks++;
            if (move_start || cast_start) nstart++;
            if (busy) nbusy++;
            if (frame_done) nfd++;
            if (col != 0) ncol++;
            if (overrun_count != 0) novr++;
            move_done = 1'($urandom_range(0, 1));
            cast_done = 1'($urandom_range(0, 1));
            step();
        end
        move_done = 0;
        cast_done = 0;
        chk("en_low_ticks", nticks, 4);
        chk("en_low_starts", nstart, 0);
        chk("en_low_busy", nbusy, 0);
        chk("en_low_frame_done", nfd, 0);
        chk("en_low_col", ncol, 0);
        chk("en_low_overrun", novr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
